// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a start bit, shifts one byte plus
// odd parity and stop on device clock falls, then samples the device acknowledge.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned START_SETUP    = 50,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kclk_in,
  input  logic       kdata_in,
  output logic       kclk_oe,
  output logic       kdata_oe,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);

  localparam int unsigned PhMax = (INHIBIT_CYCLES > START_SETUP) ? INHIBIT_CYCLES : START_SETUP;
  localparam int unsigned PhW   = (PhMax > 1) ? $clog2(PhMax) : 1;
  localparam int unsigned WdW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [PhW-1:0] InhLast   = PhW'(INHIBIT_CYCLES - 1);
  localparam logic [PhW-1:0] SetupLast = PhW'(START_SETUP - 1);
  localparam logic [WdW-1:0] WdLast    = WdW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StStart,
    StSend,
    StAck,
    StWaitIdle
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] kclk_sync, kdata_sync;
  logic                   kclk_s, kdata_s, kclk_prev, fall;

  logic [PhW-1:0] ph_q, ph_d;
  logic [WdW-1:0] wd_q, wd_d;
  logic [3:0]     bitcnt_q, bitcnt_d;
  logic [7:0]     shreg_q, shreg_d;
  logic           parity_q, parity_d;
  logic           ack_nxt_q, ack_nxt_d;
  logic           kclk_oe_d, kdata_oe_d, busy_d, done_d, ack_err_d, timeout_err_d;

  // Idle bus lines are high, so the synchronizers reset to 1 to avoid a false fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kclk_sync  <= '1;
      kdata_sync <= '1;
      kclk_prev  <= 1'b1;
    end else begin
      kclk_sync[0]  <= kclk_in;
      kdata_sync[0] <= kdata_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        kclk_sync[i]  <= kclk_sync[i-1];
        kdata_sync[i] <= kdata_sync[i-1];
      end
      kclk_prev <= kclk_s;
    end
  end

  assign kclk_s  = kclk_sync[SYNC_STAGES-1];
  assign kdata_s = kdata_sync[SYNC_STAGES-1];
  assign fall    = kclk_prev & ~kclk_s;

  always_comb begin
    state_d       = state_q;
    ph_d          = ph_q;
    wd_d          = wd_q;
    bitcnt_d      = bitcnt_q;
    shreg_d       = shreg_q;
    parity_d      = parity_q;
    ack_nxt_d     = ack_nxt_q;
    kclk_oe_d     = kclk_oe_q_w();
    kdata_oe_d    = kdata_oe;
    done_d        = 1'b0;
    ack_err_d     = 1'b0;
    timeout_err_d = 1'b0;

    case (state_q)
      StIdle: begin
        kclk_oe_d  = 1'b0;
        kdata_oe_d = 1'b0;
        if (tx_start) begin
          shreg_d   = tx_byte;
          parity_d  = ~^tx_byte;
          bitcnt_d  = '0;
          ph_d      = '0;
          kclk_oe_d = 1'b1;
          state_d   = StInhibit;
        end
      end
      StInhibit: begin
        if (ph_q == InhLast) begin
          ph_d       = '0;
          kdata_oe_d = 1'b1;
          state_d    = StStart;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      StStart: begin
        if (ph_q == SetupLast) begin
          ph_d      = '0;
          kclk_oe_d = 1'b0;
          wd_d      = '0;
          state_d   = StSend;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      StSend, StAck, StWaitIdle: begin
        // Watchdog wins over any bus event seen in the same cycle.
        if (wd_q == WdLast) begin
          kclk_oe_d     = 1'b0;
          kdata_oe_d    = 1'b0;
          done_d        = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = StIdle;
        end else begin
          wd_d = wd_q + 1'b1;
          if (state_q == StSend) begin
            if (fall) begin
              bitcnt_d = bitcnt_q + 1'b1;
              if (bitcnt_q < 4'd8) begin
                kdata_oe_d = ~shreg_q[bitcnt_q[2:0]];
              end else if (bitcnt_q == 4'd8) begin
                kdata_oe_d = ~parity_q;
              end else begin
                kdata_oe_d = 1'b0;
                state_d    = StAck;
              end
            end
          end else if (state_q == StAck) begin
            if (fall) begin
              ack_nxt_d = kdata_s;
              state_d   = StWaitIdle;
            end
          end else if (kclk_s && kdata_s) begin
            done_d     = 1'b1;
            ack_err_d  = ack_nxt_q;
            kdata_oe_d = 1'b0;
            state_d    = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  function automatic logic kclk_oe_q_w();
    return kclk_oe;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ph_q        <= '0;
      wd_q        <= '0;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      parity_q    <= 1'b0;
      ack_nxt_q   <= 1'b0;
      kclk_oe     <= 1'b0;
      kdata_oe    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      wd_q        <= wd_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      parity_q    <= parity_d;
      ack_nxt_q   <= ack_nxt_d;
      kclk_oe     <= kclk_oe_d;
      kdata_oe    <= kdata_oe_d;
      busy        <= busy_d;
      done        <= done_d;
      ack_err     <= ack_err_d;
      timeout_err <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host and
// decodes them; results are checked against hand-computed frames with immediate assertions.
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kclk_in, kdata_in;
  logic       kclk_oe, kdata_oe;
  logic       tx_start = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       busy, done, ack_err, timeout_err;

  logic dev_clk  = 1'b1;
  logic dev_data = 1'b1;

  int ntests = 0;
  int nfail  = 0;

  // Open-drain wired-AND of host and device drivers.
  assign kclk_in  = dev_clk & ~kclk_oe;
  assign kdata_in = dev_data & ~kdata_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(20),
    .START_SETUP   (4),
    .TIMEOUT_CYCLES(2000),
    .SYNC_STAGES   (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .kclk_in    (kclk_in),
    .kdata_in   (kdata_in),
    .kclk_oe    (kclk_oe),
    .kdata_oe   (kdata_oe),
    .tx_start   (tx_start),
    .tx_byte    (tx_byte),
    .busy       (busy),
    .done       (done),
    .ack_err    (ack_err),
    .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_tx(input logic [7:0] b);
    @(negedge clk);
    tx_start = 1'b1;
    tx_byte  = b;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Counts cycles of kclk_oe high and, within them, cycles before kdata_oe rises.
  task automatic measure_inhibit(output int hi, output int pre);
    int guard;
    hi = 0;
    pre = 0;
    guard = 0;
    while (kclk_oe === 1'b1 && guard < 200) begin
      hi++;
      if (kdata_oe !== 1'b1) pre++;
      @(negedge clk);
      guard++;
    end
  endtask

  // Device: 40-cycle clock, samples data just before each rising edge, acks in slot 11.
  task automatic dev_run(input int npulses, input bit ack, input int poke_at,
                         output logic [9:0] bits);
    bits = '0;
    repeat (5) @(negedge clk);
    for (int p = 1; p <= npulses; p++) begin
      dev_clk = 1'b0;
      for (int c = 0; c < 20; c++) begin
        tx_start = (p == poke_at && c == 0);
        if (p == poke_at && c == 0) tx_byte = 8'h55;
        @(negedge clk);
      end
      tx_start = 1'b0;
      if (p <= 10) bits[p-1] = kdata_in;
      if (p == 10 && ack) dev_data = 1'b0;
      if (p == 11) dev_data = 1'b1;
      dev_clk = 1'b1;
      if (p < npulses) repeat (20) @(negedge clk);
    end
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < limit);
  endtask

  task automatic send_frame(input string tag, input logic [7:0] b, input logic [9:0] exp_bits,
                            input bit ack, input int poke_at);
    int hi, pre, n;
    logic [9:0] bits;
    start_tx(b);
    check({tag, " busy after accept"}, busy, 1);
    measure_inhibit(hi, pre);
    check({tag, " kclk_oe high cycles"}, hi, 24);
    check({tag, " cycles before kdata_oe"}, pre, 20);
    check({tag, " start bit"}, kdata_in, 0);
    dev_run(11, ack, poke_at, bits);
    wait_done(200, n);
    check({tag, " done"}, done, 1);
    check({tag, " frame bits"}, bits, exp_bits);
    check({tag, " ack_err"}, ack_err, ack ? 0 : 1);
    check({tag, " timeout_err"}, timeout_err, 0);
    check({tag, " busy in done cycle"}, busy, 0);
    @(negedge clk);
    check({tag, " done one cycle"}, {done, ack_err, timeout_err}, 0);
  endtask

  initial begin : main
    int hi, pre, n, seen;
    logic [9:0] bits;

    repeat (3) @(negedge clk);
    check("reset outputs", {kclk_oe, kdata_oe, busy, done, ack_err, timeout_err}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 0xED: LSB first 1,0,1,1,0,1,1,1; six ones -> parity 1; stop 1.
    send_frame("ed", 8'hED, 10'b1_1_11101101, 1'b1, 0);
    send_frame("00", 8'h00, 10'b1_1_00000000, 1'b1, 0);
    send_frame("ff", 8'hFF, 10'b1_1_11111111, 1'b1, 0);
    send_frame("01", 8'h01, 10'b1_0_00000001, 1'b1, 0);
    send_frame("f4 noack", 8'hF4, 10'b1_0_11110100, 1'b0, 0);

    // Request with 0x55 during bit 4 must neither alter nor follow the frame.
    send_frame("3c poke", 8'h3C, 10'b1_1_00111100, 1'b1, 4);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (kclk_oe || kdata_oe || busy) seen++;
    end
    check("no extra frame", seen, 0);

    // Timeout: device never clocks after release.
    start_tx(8'hA0);
    measure_inhibit(hi, pre);
    wait_done(3000, n);
    check("timeout latency", n, 2000);
    check("timeout flags", {done, timeout_err, ack_err}, 3'b110);
    check("timeout lines", {kclk_oe, kdata_oe, busy}, 0);
    @(negedge clk);
    check("timeout idle", {done, timeout_err, busy, kclk_oe}, 0);

    // Reset after fall 4 of 0xF4 (bit 3 is 0, so kdata_oe is pulling low).
    start_tx(8'hF4);
    measure_inhibit(hi, pre);
    dev_run(4, 1'b0, 0, bits);
    check("pre-reset state", {busy, kdata_oe}, 2'b11);
    rst = 1'b1;
    #1;
    check("async reset release", {kclk_oe, kdata_oe, busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send_frame("ff after reset", 8'hFF, 10'b1_1_11111111, 1'b1, 0);

    // Device clock activity while idle is ignored.
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      dev_clk = 1'b0;
      repeat (20) begin
        @(negedge clk);
        if (kclk_oe || kdata_oe || busy || done) seen++;
      end
      dev_clk = 1'b1;
      repeat (20) begin
        @(negedge clk);
        if (kclk_oe || kdata_oe || busy || done) seen++;
      end
    end
    check("idle clock ignored", seen, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter; the outbound counterpart of the keyboard receiver (ps2Control).
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Drives kclk and kData as open-drain through active-high pull-low enables; shares the two lines with the receiver.
- Asserts busy so the receiver suppresses decoding while a host frame is on the wire.

Parameters:
- INHIBIT_CYCLES, 5000: cycles kclk is held low before the start bit (100 us at 50 MHz).
- START_SETUP, 50: cycles data is held low before kclk is released (1 us).
- TIMEOUT_CYCLES, 750000: maximum cycles from kclk release to end of frame (15 ms).
- SYNC_STAGES, 2: synchronizer flops on kclk_in and kdata_in.

Ports:
- clk, input, 1: system clock, 50 MHz.
- rst, input, 1: reset, asynchronous, active-high.
- kclk_in, input, 1: sensed PS/2 clock line.
- kdata_in, input, 1: sensed PS/2 data line.
- kclk_oe, output, 1: 1 = pull kclk low; 0 = release.
- kdata_oe, output, 1: 1 = pull kData low; 0 = release.
- tx_start, input, 1: single-cycle request; accepted only in IDLE.
- tx_byte, input, 8: byte to send; sampled when tx_start is accepted.
- busy, output, 1: high from the accept cycle until the state returns to IDLE.
- done, output, 1: one-cycle pulse at end of frame, whether successful or not.
- ack_err, output, 1: valid with done; device did not pull data low in the ack slot.
- timeout_err, output, 1: valid with done; frame aborted by the watchdog.

Behaviour:
- Reset (asynchronous, active-high): kclk_oe=0, kdata_oe=0, busy=0, done=0, ack_err=0, timeout_err=0; state IDLE; all counters 0. Reset mid-frame releases both lines immediately.
- Synchronization: kclk_in and kdata_in each pass through SYNC_STAGES flops.
- fall: asserted when the synchronized kclk is 1 in the previous cycle and 0 in the current cycle.
- Accept: in IDLE with tx_start=1:
  - latch shreg <= tx_byte;
  - parity <= ~^tx_byte (odd parity);
  - bitcnt <= 0; busy <= 1 in the next cycle; go to INHIBIT.
  - tx_start outside IDLE is ignored with no side effects.
- INHIBIT: kclk_oe=1, kdata_oe=0 for exactly INHIBIT_CYCLES cycles, then go to START.
- START: kclk_oe=1, kdata_oe=1 (start bit 0) for START_SETUP cycles. Then kclk_oe <= 0, watchdog cleared, go to SEND.
- SEND: kclk_oe=0. On each fall, in the same cycle as fall is seen, update kdata_oe:
  - falls 1..8: kdata_oe = ~shreg[bitcnt] (LSB first);
  - fall 9: kdata_oe = ~parity;
  - fall 10: kdata_oe = 0 (stop bit = released line); go to ACK.
  - bitcnt increments on every fall; 4 bits wide.
- ACK: on the next fall, sample synchronized kdata_in: ack_err_next = kdata_in (0 = acknowledged). Go to WAIT_IDLE.
- WAIT_IDLE: wait until synchronized kclk and kdata are both 1, then:
  - pulse done=1 for one cycle with ack_err=ack_err_next and timeout_err=0;
  - busy drops in the same cycle; return to IDLE.
- Watchdog:
  - counts every cycle in SEND, ACK and WAIT_IDLE;
  - on reaching TIMEOUT_CYCLES: kclk_oe=0, kdata_oe=0, done=1, timeout_err=1, ack_err=0, go to IDLE;
  - timeout has priority over a simultaneous fall.
- Counter widths: each counter is sized by $clog2 of its parameter and saturates at its terminal count; no wrap-around.
- Outputs are registered; no combinational path from inputs to outputs.
- done, ack_err and timeout_err are 0 in every cycle except the done cycle.
- Device-initiated clock activity while in IDLE is ignored; kclk_oe and kdata_oe stay 0.

Test Plan (bench parameters INHIBIT_CYCLES=20, START_SETUP=4, TIMEOUT_CYCLES=2000; device model clocks with a 40-cycle period):
- Send 0xED with the device acking: line bits after start are 1,0,1,1,0,1,1,1, parity 1, stop 1. Require done=1, ack_err=0, timeout_err=0, and busy low in the done cycle.
- Inhibit timing: kclk_oe is high for exactly 24 cycles (20 inhibit + 4 setup). kdata_oe rises exactly 20 cycles after the accept.
- Parity check: 0x00 gives parity 1; 0xFF gives parity 1; 0x01 gives parity 0. Checker decodes each frame and compares it bit-exact.
- No ack: device leaves data high in slot 11 for 0xF4. Require done=1 and ack_err=1.
- Timeout: device never clocks after release. Require done and timeout_err at watchdog count 2000 after kclk release, kclk_oe=0, kdata_oe=0, and state IDLE.
- Abuse cases:
  - tx_start with 0x55 mid-frame: frame content unchanged, no extra frame sent.
  - rst asserted at bit 4: kclk_oe=0, kdata_oe=0 and busy=0 immediately.
  - Next tx_start with 0xFF sends a clean frame.
